ad_bus_responder: RTL and testbench

Memory-side responder for the core's multiplexed address/data bus (AD_Bus). It latches an address phase, captures write data in the following cycle, inserts a parameterised number of wait states, then returns one `ready` pulse with aligned read data or with an error flag. It owns a byte-enabled word RAM and performs the sub-word lane selection and extension for loads and the lane merge for stores.

---
 rtl/ad_bus_pkg.sv | 21 ++
 rtl/ad_bus_responder_if.sv | 25 ++
 rtl/word_ram.sv | 31 +++
 rtl/ad_bus_responder.sv | 191 +++++++++++++++++++
 tb/tb_ad_bus_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/ad_bus_pkg.sv
// Shared AD_Bus types: access size encoding and responder FSM states,
// also used by the core-side load/store unit.
package ad_bus_pkg;

    localparam int BUS_W = 32;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10,
        RSVD = 2'b11
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        WAIT,
        RESP
    } resp_state_t;

endpackage

// File: rtl/ad_bus_responder_if.sv
// Multiplexed address/data bus between the core (master) and a memory responder (slave).
interface ad_bus_responder_if;
    import ad_bus_pkg::*;

    logic             address_strobe;
    logic             write;
    logic [1:0]       size;
    logic             sign_extend;
    logic [BUS_W-1:0] AD_Bus_in;
    logic [BUS_W-1:0] data_out;
    logic             ready;
    logic             error;
    logic             busy;

    modport master (
        output address_strobe, write, size, sign_extend, AD_Bus_in,
        input  data_out, ready, error, busy
    );

    modport slave (
        input  address_strobe, write, size, sign_extend, AD_Bus_in,
        output data_out, ready, error, busy
    );

endinterface

// File: rtl/word_ram.sv
// Single-port word RAM with a registered read port and per-byte write enables.
module word_ram #(
    parameter int ADDR_WORDS = 1024,
    parameter int AW         = $clog2(ADDR_WORDS)
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic          read_en,
    input  logic          write_en,
    input  logic [3:0]    byte_en,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [ADDR_WORDS];

    // Contents are deliberately not reset; only the read register is touched on reads.
    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
        if (read_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ad_bus_responder.sv
// Memory-side AD_Bus responder: address phase, optional store data phase,
// wait states, then a single ready pulse with lane-aligned load data or an error.
module ad_bus_responder
    import ad_bus_pkg::*;
#(
    parameter int ADDR_WORDS  = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic clock,
    input  logic reset,
    ad_bus_responder_if.slave bus
);

    localparam int AW = $clog2(ADDR_WORDS);
    localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

    resp_state_t   state;
    logic [AW-1:0] addr_reg;
    logic [1:0]    offset_reg;
    logic          write_reg;
    size_t         size_reg;
    logic          sext_reg;
    logic [CW-1:0] count;
    logic [31:0]   wdata_reg;
    logic [3:0]    be_reg;
    logic          resp_load;
    logic          ready_reg;
    logic          error_reg;
    logic          busy_reg;

    size_t       req_size;
    logic        access_err;
    logic [31:0] store_data;
    logic [3:0]  store_be;
    logic        last_cycle;
    logic        ram_we;
    logic        ram_re;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [3:0]  ram_be;
    logic [31:0] ram_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;

    assign req_size = size_t'(bus.size);

    always_comb begin
        access_err = 1'b0;
        case (req_size)
            HALF:    access_err = bus.AD_Bus_in[0];
            WORD:    access_err = |bus.AD_Bus_in[1:0];
            RSVD:    access_err = 1'b1;
            default: access_err = 1'b0;
        endcase
        if (bus.AD_Bus_in[31:2] >= 30'(ADDR_WORDS)) begin
            access_err = 1'b1;
        end
    end

    // Store lanes are formed live in DATA so a zero-wait store can commit straight from the bus.
    always_comb begin
        store_data = bus.AD_Bus_in;
        store_be   = 4'b1111;
        case (size_reg)
            BYTE: begin
                store_data = {24'b0, bus.AD_Bus_in[7:0]};
                store_be   = 4'b0001;
            end
            HALF: begin
                store_data = {16'b0, bus.AD_Bus_in[15:0]};
                store_be   = 4'b0011;
            end
            default: ;
        endcase
        store_data = store_data << {offset_reg, 3'b000};
        store_be   = store_be << offset_reg;
    end

    assign last_cycle = (state == WAIT && count == '0) || (state == DATA && WAIT_STATES == 0);
    assign ram_we     = !reset && write_reg && last_cycle;
    assign ram_re     = (state == IDLE && bus.address_strobe && !bus.write && !access_err && WAIT_STATES == 0)
                     || (state == WAIT && count == '0 && !write_reg);
    assign ram_addr   = (state == IDLE) ? bus.AD_Bus_in[2 +: AW] : addr_reg;
    assign ram_wdata  = (state == DATA) ? store_data : wdata_reg;
    assign ram_be     = (state == DATA) ? store_be : be_reg;

    word_ram #(.ADDR_WORDS(ADDR_WORDS), .AW(AW)) u_ram (
        .clock    (clock),
        .addr     (ram_addr),
        .read_en  (ram_re),
        .write_en (ram_we),
        .byte_en  (ram_be),
        .wdata    (ram_wdata),
        .rdata    (ram_rdata)
    );

    // The RAM read register is the data_out register; only lane selection follows it.
    assign byte_sel = ram_rdata[{offset_reg, 3'b000} +: 8];
    assign half_sel = ram_rdata[{offset_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_data = ram_rdata;
        case (size_reg)
            BYTE:    load_data = {{24{sext_reg & byte_sel[7]}}, byte_sel};
            HALF:    load_data = {{16{sext_reg & half_sel[15]}}, half_sel};
            default: ;
        endcase
    end

    assign bus.data_out = resp_load ? load_data : '0;
    assign bus.ready    = ready_reg;
    assign bus.error    = error_reg;
    assign bus.busy     = busy_reg;

    // Access FSM; ready/error/busy are registered alongside the state they describe.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            addr_reg   <= '0;
            offset_reg <= '0;
            write_reg  <= 1'b0;
            size_reg   <= BYTE;
            sext_reg   <= 1'b0;
            count      <= '0;
            wdata_reg  <= '0;
            be_reg     <= '0;
            resp_load  <= 1'b0;
            ready_reg  <= 1'b0;
            error_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.address_strobe) begin
                        addr_reg   <= bus.AD_Bus_in[2 +: AW];
                        offset_reg <= bus.AD_Bus_in[1:0];
                        write_reg  <= bus.write;
                        size_reg   <= req_size;
                        sext_reg   <= bus.sign_extend;
                        busy_reg   <= 1'b1;
                        if (access_err) begin
                            state     <= RESP;
                            ready_reg <= 1'b1;
                            error_reg <= 1'b1;
                        end else if (bus.write) begin
                            state <= DATA;
                        end else if (WAIT_STATES == 0) begin
                            state     <= RESP;
                            ready_reg <= 1'b1;
                            resp_load <= 1'b1;
                        end else begin
                            state <= WAIT;
                            count <= WAIT_LOAD;
                        end
                    end
                end
                DATA: begin
                    wdata_reg <= store_data;
                    be_reg    <= store_be;
                    if (WAIT_STATES == 0) begin
                        state     <= RESP;
                        ready_reg <= 1'b1;
                    end else begin
                        state <= WAIT;
                        count <= WAIT_LOAD;
                    end
                end
                WAIT: begin
                    if (count == '0) begin
                        state     <= RESP;
                        ready_reg <= 1'b1;
                        resp_load <= !write_reg;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    ready_reg <= 1'b0;
                    error_reg <= 1'b0;
                    busy_reg  <= 1'b0;
                    resp_load <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad_bus_responder.sv
// Scoreboard bench for ad_bus_responder: one instance with two wait states, one with none.
module tb_ad_bus_responder;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    exp_t q2[$];
    exp_t q0[$];

    ad_bus_responder_if bus2();
    ad_bus_responder_if bus0();

    ad_bus_responder #(.ADDR_WORDS(1024), .WAIT_STATES(2)) dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    ad_bus_responder #(.ADDR_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    function automatic int qsize(input int which);
        return (which == 0) ? q2.size() : q0.size();
    endfunction

    // Monitor side: every ready pulse must match the oldest outstanding expectation.
    task automatic monitorPop(input int which, input logic err, input logic [31:0] data);
        exp_t e;
        if (qsize(which) == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_ready bus%0d: ready=1 required=0 at cycle %0d", which, cyc);
        end else begin
            e = (which == 0) ? q2.pop_front() : q0.pop_front();
            checkOutput($sformatf("ready_cycle bus%0d", which), 32'(cyc), 32'(e.cyc));
            checkOutput($sformatf("error bus%0d", which), {31'b0, err}, {31'b0, e.err});
            checkOutput($sformatf("data_out bus%0d", which), data, e.data);
        end
    endtask

    always @(negedge clock) begin
        if (bus2.ready) monitorPop(0, bus2.error, bus2.data_out);
        if (bus0.ready) monitorPop(1, bus0.error, bus0.data_out);
    end

    task automatic driveBus(input int which, input logic strobe, input logic wr,
                            input logic [1:0] sz, input logic sx, input logic [31:0] ad);
        if (which == 0) begin
            bus2.address_strobe = strobe;
            bus2.write          = wr;
            bus2.size           = sz;
            bus2.sign_extend    = sx;
            bus2.AD_Bus_in      = ad;
        end else begin
            bus0.address_strobe = strobe;
            bus0.write          = wr;
            bus0.size           = sz;
            bus0.sign_extend    = sx;
            bus0.AD_Bus_in      = ad;
        end
    endtask

    task automatic waitDrain(input int which);
        int n = 0;
        while (qsize(which) != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        if (qsize(which) != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout bus%0d: outstanding=%0d required=0", which, qsize(which));
            if (which == 0) q2.delete(); else q0.delete();
        end
        @(negedge clock);
    endtask

    // Issue one access; the expectation is queued the moment the strobe goes out.
    task automatic applyStimulus(input int which, input logic wr, input logic [1:0] sz, input logic sx,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic exp_err, input logic [31:0] exp_data,
                                 input int lat, input logic hold);
        exp_t e;
        e.cyc  = cyc + lat;
        e.err  = exp_err;
        e.data = exp_data;
        if (which == 0) q2.push_back(e); else q0.push_back(e);
        driveBus(which, 1'b1, wr, sz, sx, addr);
        @(negedge clock);
        driveBus(which, hold, wr, sz, sx, wr ? wdata : addr);
        @(negedge clock);
        driveBus(which, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        waitDrain(which);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        driveBus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        driveBus(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("reset ready",    {31'b0, bus2.ready}, 32'h0);
        checkOutput("reset error",    {31'b0, bus2.error}, 32'h0);
        checkOutput("reset busy",     {31'b0, bus2.busy},  32'h0);
        checkOutput("reset data_out", bus2.data_out,       32'h0);
        checkOutput("reset busy0",    {31'b0, bus0.busy},  32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Two wait states: stores answer at N+4, loads at N+3, errors at N+1.
        applyStimulus(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        4, 0);
        applyStimulus(0, 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 3, 0);
        applyStimulus(0, 1, 2'b00, 0, 32'h13, 32'h12345680, 0, 32'h0,        4, 0);
        applyStimulus(0, 0, 2'b00, 1, 32'h13, 32'h0,        0, 32'hFFFFFF80, 3, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h13, 32'h0,        0, 32'h00000080, 3, 0);
        applyStimulus(0, 0, 2'b10, 0, 32'h10, 32'h0,        0, 32'h80ADBEEF, 3, 0);
        applyStimulus(0, 0, 2'b01, 1, 32'h12, 32'h0,        0, 32'hFFFF80AD, 3, 0);
        applyStimulus(0, 1, 2'b10, 0, 32'h20, 32'h11223344, 0, 32'h0,        4, 0);
        applyStimulus(0, 0, 2'b01, 0, 32'h21, 32'h0,        1, 32'h0,        1, 0);
        applyStimulus(0, 1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 1, 32'h0,        1, 0);
        applyStimulus(0, 0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h11223344, 3, 0);
        applyStimulus(0, 1, 2'b01, 0, 32'h22, 32'hBEEF5678, 0, 32'h0,        4, 0);
        applyStimulus(0, 0, 2'b10, 0, 32'h20, 32'h0,        0, 32'h56783344, 3, 0);
        applyStimulus(0, 0, 2'b01, 0, 32'h22, 32'h0,        0, 32'h00005678, 3, 0);
        applyStimulus(0, 0, 2'b10, 0, 32'h1000, 32'h0,      1, 32'h0,        1, 0);
        applyStimulus(0, 0, 2'b11, 0, 32'h20, 32'h0,        1, 32'h0,        1, 0);
        applyStimulus(0, 1, 2'b10, 0, 32'h40, 32'hA5A5A5A5, 0, 32'h0,        4, 0);

        // Reset lands while the store to 0x40 is waiting; it must not commit.
        driveBus(0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40);
        @(negedge clock);
        driveBus(0, 1'b0, 1'b1, 2'b10, 1'b0, 32'h12345678);
        @(negedge clock);
        driveBus(0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0);
        checkOutput("busy in wait", {31'b0, bus2.busy}, 32'h1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort ready",    {31'b0, bus2.ready}, 32'h0);
        checkOutput("abort error",    {31'b0, bus2.error}, 32'h0);
        checkOutput("abort busy",     {31'b0, bus2.busy},  32'h0);
        checkOutput("abort data_out", bus2.data_out,       32'h0);
        reset = 1'b0;
        @(negedge clock);
        applyStimulus(0, 0, 2'b10, 0, 32'h40, 32'h0,        0, 32'hA5A5A5A5, 3, 0);

        // Zero wait states; the second load strobe arrives while busy and must be dropped.
        applyStimulus(1, 1, 2'b10, 0, 32'h8, 32'hCAFEF00D, 0, 32'h0,        2, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h8, 32'h0,        0, 32'hCAFEF00D, 1, 1);
        applyStimulus(1, 0, 2'b01, 1, 32'hA, 32'h0,        0, 32'hFFFFCAFE, 1, 0);
        applyStimulus(1, 1, 2'b11, 0, 32'h8, 32'h0,        1, 32'h0,        1, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h8, 32'h0,        0, 32'hCAFEF00D, 1, 0);

        repeat (5) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
